// File: rtl/control_unit_if.sv
// Bus bundle between the control unit and its ROM/accumulator datapath.
// The control unit is the master; the datapath side (or a bench) uses the slave view.
interface control_unit_if;
  logic       start;
  logic [7:0] rom_data;
  logic       acc_zero;
  logic [3:0] rom_addr;
  logic       acc_enable;
  logic [2:0] alu_op;
  logic [7:0] operand;
  logic       busy;
  logic       done;

  modport master (
    input  start, rom_data, acc_zero,
    output rom_addr, acc_enable, alu_op, operand, busy, done
  );

  modport slave (
    output start, rom_data, acc_zero,
    input  rom_addr, acc_enable, alu_op, operand, busy, done
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer for a 4-bit-PC accumulator machine.
// One instruction every three cycles, no overlap; opcode F parks the unit in HALT.
module control_unit (
  input  logic           clock,
  input  logic           reset,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;

  logic [7:0] dec_word;
  logic [3:0] dec_opcode;
  logic [3:0] dec_imm;
  logic [2:0] dec_alu_op;
  logic       dec_writes_acc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= 4'h0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // During DECODE the word is only on the ROM bus; in EXECUTE it comes from ir_q,
  // so alu_op/operand carry the same value across both cycles.
  always_comb begin
    dec_word   = (state_q == S_DECODE) ? bus.rom_data : ir_q;
    dec_opcode = dec_word[7:4];
    dec_imm    = dec_word[3:0];
  end

  always_comb begin
    dec_alu_op     = 3'd0;
    dec_writes_acc = 1'b0;
    case (dec_opcode)
      4'h1: begin dec_alu_op = 3'd0; dec_writes_acc = 1'b1; end
      4'h2: begin dec_alu_op = 3'd1; dec_writes_acc = 1'b1; end
      4'h3: begin dec_alu_op = 3'd2; dec_writes_acc = 1'b1; end
      4'h4: begin dec_alu_op = 3'd3; dec_writes_acc = 1'b1; end
      4'h5: begin dec_alu_op = 3'd4; dec_writes_acc = 1'b1; end
      4'h6: begin dec_alu_op = 3'd5; dec_writes_acc = 1'b1; end
      default: begin
        dec_alu_op     = 3'd0;
        dec_writes_acc = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    bus.rom_addr   = pc_q;
    bus.acc_enable = 1'b0;
    bus.alu_op     = 3'd0;
    bus.operand    = 8'h00;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = 4'h0;
        end
      end

      S_FETCH: begin
        bus.busy = 1'b1;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        bus.busy    = 1'b1;
        ir_d        = bus.rom_data;
        bus.alu_op  = dec_alu_op;
        bus.operand = {4'h0, dec_imm};
        state_d     = S_EXECUTE;
      end

      S_EXECUTE: begin
        bus.busy       = 1'b1;
        bus.alu_op     = dec_alu_op;
        bus.operand    = {4'h0, dec_imm};
        bus.acc_enable = dec_writes_acc;
        // HALT keeps pc on the halting instruction so rom_addr shows where it stopped.
        if (dec_opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          if ((dec_opcode == OP_JMP) || ((dec_opcode == OP_JZ) && bus.acc_zero)) begin
            pc_d = dec_imm;
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end

      S_HALT: begin
        bus.done = 1'b1;
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = 4'h0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: program table plus hand-written corner sequences,
// with accumulator write pulses checked against a queue of expected {alu_op, operand}.
module tb_control_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;

  control_unit_if bus ();

  control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Synchronous instruction ROM: data appears the cycle after the address.
  logic [7:0] rom [16];
  always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  typedef struct packed {
    logic [2:0] alu_op;
    logic [7:0] operand;
  } pulse_t;

  pulse_t exp_q[$];
  int     total = 0;
  int     bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] prog;    // bytes for ROM[0..3], ROM[0] in the top byte
    logic        az;
    int          np;      // expected acc_enable pulses
    logic [15:0] ops;     // alu_op per pulse, one nibble each, first pulse in the top nibble
    logic [31:0] opnds;   // operand per pulse, one byte each
    logic [3:0]  fpc;
    int          cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe consumes one expected entry; the previous (DECODE)
  // cycle must already have shown the same ALU controls.
  logic [2:0] prev_op   = 3'd0;
  logic [7:0] prev_opnd = 8'h00;
  always @(negedge clock) begin
    pulse_t e;
    if (bus.acc_enable === 1'b1) begin
      check("pulse_busy", {31'd0, bus.busy}, 32'd1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL acc_pulse: got pulse alu_op=%0d operand=%0h required no pulse",
                 bus.alu_op, bus.operand);
      end else begin
        e = exp_q.pop_front();
        $display("pulse alu_op=%0d operand=%0h", bus.alu_op, bus.operand);
        check("exec_alu_op", {29'd0, bus.alu_op}, {29'd0, e.alu_op});
        check("decode_alu_op", {29'd0, prev_op}, {29'd0, e.alu_op});
        if (e.alu_op != 3'd5) begin
          check("exec_operand", {24'd0, bus.operand}, {24'd0, e.operand});
          check("decode_operand", {24'd0, prev_opnd}, {24'd0, e.operand});
        end
      end
    end
    prev_op   = bus.alu_op;
    prev_opnd = bus.operand;
  end

  task automatic fill_rom(input logic [31:0] prog);
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    for (int i = 0; i < 4; i++) rom[i] = prog[31-8*i -: 8];
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [7:0] opnd);
    pulse_t p;
    p.alu_op  = op;
    p.operand = opnd;
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done within 200 cycles required done", name);
    end
  endtask

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.acc_zero = 1'b0;
    fill_rom(32'hF0F0F0F0);

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rom_addr", {28'd0, bus.rom_addr}, 32'd0);
    check("rst_acc_enable", {31'd0, bus.acc_enable}, 32'd0);
    check("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    check("rst_operand", {24'd0, bus.operand}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b1;

    vecs[0] = '{name:"ldi_add",   prog:32'h1523F0F0, az:1'b0, np:2, ops:16'h0100,
                opnds:32'h05030000, fpc:4'd2, cyc:9};
    vecs[1] = '{name:"jz_taken",  prog:32'h1084F0F0, az:1'b1, np:1, ops:16'h0000,
                opnds:32'h00000000, fpc:4'd4, cyc:9};
    vecs[2] = '{name:"jz_not",    prog:32'h1084F0F0, az:1'b0, np:1, ops:16'h0000,
                opnds:32'h00000000, fpc:4'd2, cyc:9};
    vecs[3] = '{name:"alu_mix",   prog:32'h3142536F, az:1'b0, np:4, ops:16'h2345,
                opnds:32'h01020300, fpc:4'd4, cyc:15};
    vecs[4] = '{name:"undef_nop", prog:32'hA790F0F0, az:1'b1, np:0, ops:16'h0000,
                opnds:32'h00000000, fpc:4'd2, cyc:9};
    vecs[5] = '{name:"jmp_fwd",   prog:32'h72F016F0, az:1'b0, np:1, ops:16'h0000,
                opnds:32'h06000000, fpc:4'd3, cyc:9};

    foreach (vecs[v]) begin
      do_reset();
      fill_rom(vecs[v].prog);
      bus.acc_zero = vecs[v].az;
      for (int i = 0; i < vecs[v].np; i++) begin
        logic [3:0] nib;
        nib = vecs[v].ops[15-4*i -: 4];
        push_exp(nib[2:0], vecs[v].opnds[31-8*i -: 8]);
      end
      pulse_start();
      wait_done(vecs[v].name, n);
      $display("vec %s: cycles=%0d rom_addr=%0d", vecs[v].name, n, bus.rom_addr);
      check({vecs[v].name, "_cycles"}, n, vecs[v].cyc);
      check({vecs[v].name, "_rom_addr"}, {28'd0, bus.rom_addr}, {28'd0, vecs[v].fpc});
      check({vecs[v].name, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({vecs[v].name, "_pending"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end

    // JMP 15 onto a NOP at the top of ROM: pc wraps to 0
    do_reset();
    bus.acc_zero = 1'b0;
    fill_rom(32'h7FF0F0F0);
    rom[15] = 8'h00;
    pulse_start();
    check("wrap_fetch0", {28'd0, bus.rom_addr}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("wrap_fetch15", {28'd0, bus.rom_addr}, 32'd15);
    check("wrap_busy", {31'd0, bus.busy}, 32'd1);
    repeat (3) @(posedge clock);
    #1;
    check("wrap_fetch_after_nop", {28'd0, bus.rom_addr}, 32'd0);
    $display("seq wrap: rom_addr=%0d", bus.rom_addr);

    // Reset asserted during DECODE of ADD: no ADD write
    do_reset();
    fill_rom(32'h1523F0F0);
    push_exp(3'd0, 8'h05);
    pulse_start();
    repeat (4) @(posedge clock);
    #1;
    check("mid_decode_alu_op", {29'd0, bus.alu_op}, 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("mid_rst_rom_addr", {28'd0, bus.rom_addr}, 32'd0);
    check("mid_rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    check("mid_rst_operand", {24'd0, bus.operand}, 32'd0);
    check("mid_rst_acc_enable", {31'd0, bus.acc_enable}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("mid_rst_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_pending", exp_q.size(), 32'd0);
    $display("seq reset_in_decode: busy=%0d", bus.busy);

    // start during EXECUTE is ignored; start in HALT restarts from 0
    do_reset();
    fill_rom(32'h1523F0F0);
    push_exp(3'd0, 8'h05);
    push_exp(3'd1, 8'h03);
    pulse_start();
    repeat (2) @(posedge clock);
    #1;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check("busy_start_rom_addr", {28'd0, bus.rom_addr}, 32'd1);
    wait_done("busy_start", n);
    check("busy_start_cycles", n + 3, 32'd9);
    check("busy_start_final", {28'd0, bus.rom_addr}, 32'd2);
    check("busy_start_pending", exp_q.size(), 32'd0);
    push_exp(3'd0, 8'h05);
    push_exp(3'd1, 8'h03);
    pulse_start();
    check("halt_restart_busy", {31'd0, bus.busy}, 32'd1);
    check("halt_restart_done", {31'd0, bus.done}, 32'd0);
    check("halt_restart_rom_addr", {28'd0, bus.rom_addr}, 32'd0);
    wait_done("halt_restart", n);
    check("halt_restart_cycles", n, 32'd9);
    check("halt_restart_final", {28'd0, bus.rom_addr}, 32'd2);
    check("halt_restart_pending", exp_q.size(), 32'd0);
    $display("seq halt_restart: cycles=%0d rom_addr=%0d", n, bus.rom_addr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
